weight_store_ctrl: RTL and testbench
====================================

// Module: weight_store_ctrl
// PURPOSE
//  Parametrised weight memory for the drowsiness-detector NN: DEPTH words of W bits.
//  Random initialisation from an internal LFSR; zero-clear; N-lane burst read and burst write.
//  Commands use a valid/ready handshake; an FSM sequences the multi-cycle fill operations.
//  Sits between the training/inference controller and the neuron datapath, which consumes Q[0:N-1].
// PARAMETERS
//  W      10       weight word width in bits (1..16)
//  DEPTH  65       number of weight words
//  N      10       lanes per burst (1..DEPTH)
//  AW     $clog2(DEPTH)  address width (derived; do not override)
//  SEED   16'hACE1 LFSR load value at reset (must be nonzero)
// PORTS
//  Clock      in   1      single system clock; everything is rising-edge
//  Rst        in   1      synchronous, active-low reset
//  cmd_valid  in   1      command present
//  cmd_ready  out  1      block can accept a command (1 only in IDLE)
//  cmd_op     in   2      00 READ, 01 WRITE, 10 INIT (random), 11 CLEAR (zero)
//  Address    in   AW     base word address for READ/WRITE; ignored for INIT/CLEAR
//  D          in   W x N  write lanes D[0:N-1]
//  Q          out  W x N  read lanes Q[0:N-1]
//  q_valid    out  1      1-cycle pulse: Q holds a new READ result
//  done       out  1      1-cycle pulse: WRITE/INIT/CLEAR finished, or a command rejected
//  err        out  1      1-cycle pulse, coincident with done: Address >= DEPTH, command dropped
// BEHAVIOUR
//  - Reset (Rst=0 at an edge): FSM->IDLE, cmd_ready=1, Q[*]=0, q_valid=done=err=0, fill counter=0,
//    LFSR=SEED. Memory array is NOT reset (contents retained). Reset wins over any other event.
//  - Accept: cmd_valid && cmd_ready at an edge. Op, Address and D are sampled at that edge only.
//  - Address >= DEPTH on READ/WRITE: no memory or Q change; done=err=1 on the next cycle; back to IDLE.
//  - Lane addressing: lane i uses word (Address+i) mod DEPTH. Burst wraps past DEPTH-1 to word 0.
//  - READ: Q[i] <= mem[(Address+i) mod DEPTH] at the accept edge. q_valid=1 the following cycle.
//    Latency is 1. Q holds its value until the next READ or reset. FSM stays in IDLE.
//  - WRITE: mem[(Address+i) mod DEPTH] <= D[i] for all i at the accept edge; done=1 the next cycle.
//    N > DEPTH is illegal by parameter range; no lane aliasing can occur.
//  - INIT: IDLE->FILL, cmd_ready=0. Each cycle: mem[cnt] <= lfsr[W-1:0], LFSR steps, cnt++.
//    Words 0..DEPTH-1 are written over DEPTH cycles. After the last write: done=1, IDLE, cmd_ready=1.
//  - CLEAR: identical to INIT, but each word written is 0. The LFSR does not step.
//  - Command-to-done latency: READ q_valid at +1; WRITE done at +1; INIT/CLEAR done at +DEPTH+1.
//  - LFSR: 16-bit Fibonacci, taps 16,14,13,11 (x^16+x^14+x^13+x^11+1), shifts left, feedback into bit 0.
//    Steps only during INIT fill cycles, so the sequence continues across successive INITs.
//  - Reset during FILL: aborts the fill immediately. Words already written keep their values.
//    No done pulse is issued. The next INIT restarts at word 0 from SEED.
//  - cmd_valid while cmd_ready=0: ignored, not queued. The master holds it until cmd_ready.
//  - q_valid, done and err never assert during reset or in the same cycle as an accept.
// STRUCTURE
//  - Package weight_store_pkg: typedef enum logic[1:0] {OP_READ, OP_WRITE, OP_INIT, OP_CLEAR} op_t;
//    typedef enum {S_IDLE, S_FILL, S_RESP} state_t; localparam LFSR_W=16, LFSR_TAPS=16'hB400.
//  - Sub-module weight_lfsr #(SEED): ports Clock, Rst, en, q[15:0]; synchronous load of SEED on reset.
//  - Top level holds the FSM, fill counter, memory array, lane-address modulo logic and response pulses.
// TESTING
//  1. Reset, then INIT: cmd_ready=0 for 65 cycles, done at +66; mem[0]=lfsr(SEED)[9:0]=0x0E1, mem[1]=next LFSR word.
//  2. WRITE Address=3, D[i]=i+1; then READ Address=3 -> q_valid 1 cycle later, Q=1..10.
//  3. Wrap: WRITE Address=60, D[i]=0x100+i -> mem[60..64]=0x100..0x104, mem[0..4]=0x105..0x109; READ 60 matches.
//  4. READ Address=70 -> done=err=1 next cycle, Q unchanged, q_valid stays 0.
//  5. Rst=0 at fill cycle 20 of INIT -> cmd_ready=1 next cycle, no done; mem[20..64] keep prior values.
//  6. CLEAR then READ 0 and READ 55 -> all Q lanes 0; cmd_valid pulsed during CLEAR is ignored (no extra done).

Source files
------------

// File: rtl/weight_store_pkg.sv
// ---------------------------------------------------------------------------
// weight_store_pkg
//   Shared types and constants for the weight store controller:
//   command opcodes, controller FSM states and the LFSR polynomial used for
//   random weight initialisation.
// ---------------------------------------------------------------------------
package weight_store_pkg;

    // Command opcodes as seen on cmd_op.
    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_INIT  = 2'b10,
        OP_CLEAR = 2'b11
    } op_t;

    // S_RESP names the response cycle. Response pulses are registered, so the
    // FSM goes straight back to S_IDLE and this encoding is never entered.
    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_RESP
    } state_t;

    localparam int                LFSR_W    = 16;
    // x^16 + x^14 + x^13 + x^11 + 1 -> state bits 15, 13, 12, 10.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    // One Fibonacci step: shift left, XOR of the tapped bits enters bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/weight_lfsr.sv
// ---------------------------------------------------------------------------
// weight_lfsr
//   16-bit Fibonacci LFSR that supplies random initial weights.
//   Ports:
//     Clock  in   system clock, rising edge
//     Rst    in   synchronous active-low reset, loads SEED
//     en     in   advance the sequence by one step
//     q      out  current LFSR state
// ---------------------------------------------------------------------------
module weight_lfsr
    import weight_store_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              Clock,
    input  logic              Rst,
    input  logic              en,
    output logic [LFSR_W-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge Clock) begin
        if (!Rst) begin
            q <= SEED;
        end else if (en) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/weight_store_ctrl.sv
// ---------------------------------------------------------------------------
// weight_store_ctrl
//   DEPTH x W weight memory for the NN datapath with N-lane burst read/write,
//   LFSR random fill (INIT) and zero fill (CLEAR). Commands use valid/ready;
//   the FSM sequences the DEPTH-cycle fill operations.
//   Ports:
//     Clock      in   system clock, rising edge
//     Rst        in   synchronous active-low reset
//     cmd_valid  in   command present
//     cmd_ready  out  command accepted this cycle if cmd_valid (IDLE only)
//     cmd_op     in   00 READ, 01 WRITE, 10 INIT, 11 CLEAR
//     Address    in   base word address for READ/WRITE
//     D          in   write lanes, lane i at D[i*W +: W]
//     Q          out  read lanes, lane i at Q[i*W +: W]
//     q_valid    out  1-cycle pulse: Q holds a new READ result
//     done       out  1-cycle pulse: WRITE/INIT/CLEAR finished or command rejected
//     err        out  1-cycle pulse with done: address out of range
// ---------------------------------------------------------------------------
module weight_store_ctrl
    import weight_store_pkg::*;
#(
    parameter int                W     = 10,
    parameter int                DEPTH = 65,
    parameter int                N     = 10,
    parameter int                AW    = $clog2(DEPTH),
    parameter logic [LFSR_W-1:0] SEED  = 16'hACE1
) (
    input  logic            Clock,
    input  logic            Rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [1:0]      cmd_op,
    input  logic [AW-1:0]   Address,
    input  logic [W*N-1:0]  D,
    output logic [W*N-1:0]  Q,
    output logic            q_valid,
    output logic            done,
    output logic            err
);

    // One extra bit so base + lane offset cannot overflow before the wrap.
    localparam int SW = AW + 1;

    logic [W-1:0]      r_mem [DEPTH];
    state_t            r_state;
    state_t            w_state_nxt;
    logic [AW-1:0]     r_cnt;
    logic              r_fill_rand;
    logic [W*N-1:0]    r_q;
    logic              r_q_valid;
    logic              r_done;
    logic              r_err;

    op_t               w_op;
    logic              w_accept;
    logic              w_addr_ok;
    logic              w_fill_we;
    logic              w_fill_last;
    logic              w_lfsr_en;
    logic [LFSR_W-1:0] w_lfsr;
    logic [AW-1:0]     w_lane_addr [N];
    logic [W*N-1:0]    w_rd_lanes;

    assign w_op        = op_t'(cmd_op);
    assign cmd_ready   = (r_state == S_IDLE);
    assign w_accept    = cmd_valid && cmd_ready;
    assign w_addr_ok   = ({1'b0, Address} < SW'(DEPTH));
    assign w_fill_last = (r_cnt == AW'(DEPTH - 1));

    assign Q       = r_q;
    assign q_valid = r_q_valid;
    assign done    = r_done;
    assign err     = r_err;

    // Lane i addresses (Address + i) mod DEPTH. Both terms are below DEPTH for
    // a legal address, so a single conditional subtract performs the modulo.
    for (genvar g = 0; g < N; g++) begin : g_lane
        logic [SW-1:0] w_sum;
        assign w_sum             = {1'b0, Address} + SW'(g);
        assign w_lane_addr[g]    = (w_sum >= SW'(DEPTH)) ? AW'(w_sum - SW'(DEPTH))
                                                         : w_sum[AW-1:0];
        assign w_rd_lanes[g*W +: W] = r_mem[w_lane_addr[g]];
    end

    weight_lfsr #(.SEED(SEED)) u_lfsr (
        .Clock (Clock),
        .Rst   (Rst),
        .en    (w_lfsr_en),
        .q     (w_lfsr)
    );

    // Next-state logic. READ/WRITE complete at the accept edge and never
    // leave IDLE; only the fill commands need the multi-cycle FILL state.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the case can leave a latch behind.
        w_state_nxt = r_state;
        w_fill_we   = 1'b0;
        w_lfsr_en   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept && (w_op == OP_INIT || w_op == OP_CLEAR)) begin
                    w_state_nxt = S_FILL;
                end
            end
            S_FILL: begin
                w_fill_we = 1'b1;
                w_lfsr_en = r_fill_rand;
                if (w_fill_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_fill_rand <= 1'b0;
            r_q         <= '0;
            r_q_valid   <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_q_valid <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;

            if (w_accept) begin
                unique case (w_op)
                    OP_READ: begin
                        if (w_addr_ok) begin
                            r_q       <= w_rd_lanes;
                            r_q_valid <= 1'b1;
                        end else begin
                            r_done <= 1'b1;
                            r_err  <= 1'b1;
                        end
                    end
                    OP_WRITE: begin
                        r_done <= 1'b1;
                        r_err  <= !w_addr_ok;
                    end
                    OP_INIT, OP_CLEAR: begin
                        r_fill_rand <= (w_op == OP_INIT);
                        r_cnt       <= '0;
                    end
                endcase
            end

            if (w_fill_we) begin
                if (w_fill_last) begin
                    r_cnt  <= '0;
                    r_done <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + AW'(1);
                end
            end
        end
    end

    // NOTE: the weight array is deliberately not reset; contents survive a
    // reset and only the write enables are gated by Rst.
    always_ff @(posedge Clock) begin
        if (Rst) begin
            if (w_fill_we) begin
                r_mem[r_cnt] <= r_fill_rand ? W'(w_lfsr) : '0;
            end else if (w_accept && w_op == OP_WRITE && w_addr_ok) begin
                for (int i = 0; i < N; i++) begin
                    r_mem[w_lane_addr[i]] <= D[i*W +: W];
                end
            end
        end
    end

endmodule

// File: tb/tb_weight_store_ctrl.sv
// ---------------------------------------------------------------------------
// tb_weight_store_ctrl
//   Self-checking bench for weight_store_ctrl: a table of burst READ/WRITE
//   vectors with precomputed results, hand-written INIT/CLEAR/reset-abort
//   sequences, a reference memory + LFSR model and a response scoreboard.
// ---------------------------------------------------------------------------
module tb_weight_store_ctrl;

    localparam int          W     = 10;
    localparam int          DEPTH = 65;
    localparam int          N     = 10;
    localparam int          AW    = $clog2(DEPTH);
    localparam int          WN    = W * N;
    localparam logic [15:0] SEED  = 16'hACE1;

    localparam logic [1:0] C_READ  = 2'b00;
    localparam logic [1:0] C_WRITE = 2'b01;
    localparam logic [1:0] C_INIT  = 2'b10;
    localparam logic [1:0] C_CLEAR = 2'b11;

    logic          Clock;
    logic          Rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] Address;
    logic [WN-1:0] D;
    logic [WN-1:0] Q;
    logic          q_valid;
    logic          done;
    logic          err;

    weight_store_ctrl #(
        .W     (W),
        .DEPTH (DEPTH),
        .N     (N),
        .SEED  (SEED)
    ) dut (
        .Clock     (Clock),
        .Rst       (Rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .Address   (Address),
        .D         (D),
        .Q         (Q),
        .q_valid   (q_valid),
        .done      (done),
        .err       (err)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    typedef struct {
        bit            is_read;
        bit            err;
        logic [WN-1:0] q;
        string         tag;
    } resp_t;

    typedef struct {
        logic [1:0]    op;
        int            addr;
        logic [WN-1:0] d;
        logic [WN-1:0] exp_q;
        int            lat;
    } vec_t;

    int          n_checks  = 0;
    int          n_errors  = 0;
    int          last_busy = 0;
    resp_t       sb[$];
    logic [W-1:0] mem_m [DEPTH];
    logic [15:0] lfsr_m;

    task automatic check(input string name, input logic [WN-1:0] act, input logic [WN-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [WN-1:0] model_read(input int a);
        logic [WN-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = mem_m[(a + i) % DEPTH];
        return r;
    endfunction

    // Response monitor: every q_valid/done pulse must match the oldest
    // outstanding expectation.
    always @(negedge Clock) begin
        if (Rst === 1'b1) begin
            if (q_valid === 1'b1 || done === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_pulse", {q_valid, done}, 2'b00);
                end else begin
                    resp_t e;
                    e = sb.pop_front();
                    if (e.is_read) begin
                        check({e.tag, "_kind"}, {q_valid, done}, 2'b10);
                        check({e.tag, "_q"}, Q, e.q);
                    end else begin
                        check({e.tag, "_kind"}, {q_valid, done}, 2'b01);
                        check({e.tag, "_err"}, err, e.err);
                    end
                end
            end else if (err === 1'b1) begin
                check("err_without_done", err, 1'b0);
            end
        end
    end

    // Issue one command, update the model, push the expected response and
    // wait (bounded) for it. Optionally pokes cmd_valid during a fill.
    task automatic issue(input logic [1:0] op, input int addr, input logic [WN-1:0] d,
                         input logic [WN-1:0] exp_q, input int lat, input bit poke,
                         input string name);
        resp_t e;
        int    cyc;
        int    wait_cyc;
        bit    bad;
        wait_cyc = 0;
        while (cmd_ready !== 1'b1 && wait_cyc < 100) begin
            @(posedge Clock); #1;
            wait_cyc++;
        end
        if (cmd_ready !== 1'b1) check({name, "_ready"}, cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        Address   = AW'(addr);
        D         = d;
        bad       = (op == C_READ || op == C_WRITE) && addr >= DEPTH;
        e.is_read = (op == C_READ) && !bad;
        e.err     = bad;
        e.q       = exp_q;
        e.tag     = name;
        if (op == C_WRITE && !bad) begin
            for (int i = 0; i < N; i++) mem_m[(addr + i) % DEPTH] = d[i*W +: W];
        end else if (op == C_INIT) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_m[k] = lfsr_m[W-1:0];
                lfsr_m   = lfsr_step(lfsr_m);
            end
        end else if (op == C_CLEAR) begin
            for (int k = 0; k < DEPTH; k++) mem_m[k] = '0;
        end
        sb.push_back(e);
        @(posedge Clock); #1;
        cmd_valid = 1'b0;
        cyc       = 1;
        last_busy = 0;
        forever begin
            if (poke && cyc == 10) begin
                cmd_valid = 1'b1;
                cmd_op    = C_WRITE;
                Address   = AW'(2);
                D         = '1;
            end
            if (poke && cyc == 13) cmd_valid = 1'b0;
            if (cmd_ready === 1'b0) last_busy++;
            @(negedge Clock); #1;
            if (sb.size() == 0 || cyc >= DEPTH + 10) break;
            @(posedge Clock); #1;
            cyc++;
        end
        check({name, "_latency"}, cyc, lat);
        sb.delete();
        @(posedge Clock); #1;
    endtask

    vec_t          vt[9];
    logic [WN-1:0] d_inc, d_wrap, r0, r64, r3b, ones;

    initial begin
        Rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = C_READ;
        Address   = '0;
        D         = '0;
        lfsr_m    = SEED;
        repeat (3) @(posedge Clock);
        #1;
        Rst = 1'b1;

        // Reset state
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_q_valid", q_valid, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_q", Q, '0);

        // INIT: 65 busy cycles, done at +66, then sweep the whole array
        issue(C_INIT, 0, '0, '0, DEPTH + 1, 1'b0, "init1");
        check("init1_busy", last_busy, DEPTH);
        issue(C_READ, 0, '0, model_read(0), 1, 1'b0, "init1_rd0");
        check("init1_word0", Q[W-1:0], 10'h0E1);
        check("init1_word1", Q[2*W-1:W], 10'h1C3);
        for (int a = 10; a <= 60; a += 10) begin
            issue(C_READ, a, '0, model_read(a), 1, 1'b0, $sformatf("init1_rd%0d", a));
        end

        // Table-driven burst READ/WRITE, wrap and out-of-range vectors
        for (int i = 0; i < N; i++) begin
            d_inc[i*W +: W]  = W'(i + 1);
            d_wrap[i*W +: W] = W'(10'h100 + i);
            r0[i*W +: W]     = (i < 5) ? W'(10'h105 + i) : W'(i - 2);
            r64[i*W +: W]    = (i < 6) ? W'(10'h104 + i) : W'(i - 3);
            r3b[i*W +: W]    = (i < 2) ? W'(10'h108 + i) : W'(i + 1);
        end
        ones  = '1;
        vt[0] = '{C_WRITE,  3, d_inc,  '0,     1};
        vt[1] = '{C_READ,   3, '0,     d_inc,  1};
        vt[2] = '{C_WRITE, 60, d_wrap, '0,     1};
        vt[3] = '{C_READ,  60, '0,     d_wrap, 1};
        vt[4] = '{C_READ,   0, '0,     r0,     1};
        vt[5] = '{C_READ,  64, '0,     r64,    1};
        vt[6] = '{C_READ,  70, '0,     r64,    1};
        vt[7] = '{C_WRITE, 65, ones,   r64,    1};
        vt[8] = '{C_READ,   3, '0,     r3b,    1};
        for (int k = 0; k < 9; k++) begin
            issue(vt[k].op, vt[k].addr, vt[k].d, vt[k].exp_q, vt[k].lat, 1'b0,
                  $sformatf("vec%0d", k));
            if (vt[k].op == C_READ || vt[k].addr >= DEPTH) begin
                check($sformatf("vec%0d_q_hold", k), Q, vt[k].exp_q);
            end
        end

        // Reset at fill cycle 20 of an INIT: words 0..19 written, rest kept
        cmd_valid = 1'b1;
        cmd_op    = C_INIT;
        @(posedge Clock); #1;
        cmd_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            mem_m[k] = lfsr_m[W-1:0];
            lfsr_m   = lfsr_step(lfsr_m);
        end
        repeat (20) begin
            @(posedge Clock); #1;
        end
        check("abort_busy", cmd_ready, 1'b0);
        Rst = 1'b0;
        @(posedge Clock); #1;
        Rst    = 1'b1;
        lfsr_m = SEED;
        check("abort_cmd_ready", cmd_ready, 1'b1);
        check("abort_done", done, 1'b0);
        check("abort_q_valid", q_valid, 1'b0);
        check("abort_q", Q, '0);
        repeat (DEPTH + 5) begin
            @(posedge Clock); #1;
        end
        for (int a = 0; a <= 60; a += 10) begin
            issue(C_READ, a, '0, model_read(a), 1, 1'b0, $sformatf("abort_rd%0d", a));
        end

        // CLEAR with a stray cmd_valid mid-fill, then zero reads
        issue(C_CLEAR, 0, '0, '0, DEPTH + 1, 1'b1, "clear");
        issue(C_READ, 0, '0, model_read(0), 1, 1'b0, "clear_rd0");
        check("clear_rd0_zero", Q, '0);
        issue(C_READ, 55, '0, model_read(55), 1, 1'b0, "clear_rd55");
        check("clear_rd55_zero", Q, '0);

        // INIT after the aborted one restarts from SEED
        issue(C_INIT, 0, '0, '0, DEPTH + 1, 1'b0, "init2");
        issue(C_READ, 0, '0, model_read(0), 1, 1'b0, "init2_rd0");
        check("init2_word0", Q[W-1:0], 10'h0E1);
        check("init2_word1", Q[2*W-1:W], 10'h1C3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
